// File: rtl/cart_load_if.sv
// rtl/cart_load_if.sv - hps_io download, ROM dpram port A and core-control bundle for cart_load_ctrl
interface cart_load_if #(
  parameter int ADDR_W = 15
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [23:0]       file_ext;
  logic [1:0]        sc_mode;
  logic              ext_tag_s;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic [7:0]        mem_q;
  logic              core_reset;
  logic [ADDR_W+1:0] rom_size;
  logic [3:0]        force_bs;
  logic              sc;
  logic              busy;
  logic              overflow;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, file_ext, sc_mode, ext_tag_s, mem_q,
    input  mem_addr, mem_din, mem_we, core_reset, rom_size, force_bs, sc, busy, overflow
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, file_ext, sc_mode, ext_tag_s, mem_q,
    output mem_addr, mem_din, mem_we, core_reset, rom_size, force_bs, sc, busy, overflow
  );
endinterface

// File: rtl/cart_load_ctrl.sv
// rtl/cart_load_ctrl.sv - cartridge download sequencer with ROM mirroring and core reset hold
// Optional CART_CHECKSUM_EN adds a 16-bit sum of accepted download bytes.
module cart_load_ctrl #(
  parameter int ADDR_W   = 15,
  parameter int HOLD_CYC = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
`ifdef CART_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  cart_load_if.slave  bus
);
  typedef enum logic [2:0] {HOLD, IDLE, LOAD, MIR_RD, MIR_WAIT, MIR_WR} state_t;

  localparam int CW = $clog2(HOLD_CYC + 1);
  localparam int SW = ADDR_W + 2;
  localparam logic [CW-1:0]     HOLD_INIT = CW'(HOLD_CYC);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [SW-1:0]     SIZE_ONE  = SW'(1);
  localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
  localparam logic [SW-1:0]     ROM_BYTES = {2'b01, {ADDR_W{1'b0}}};

  state_t            state, next_state;
  logic              dl_prev, end_pend;
  logic [CW-1:0]     hold_cnt;
  logic [ADDR_W-1:0] a, p_mask;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic [SW-1:0]     rom_size;
  logic [3:0]        force_bs, bs_code;
  logic              sc, sc_code, overflow;
  logic              rise, fall, in_rom, wr_ok, load_done, no_mirror, a_lt_p;
  logic [SW-1:0]     addr_p1;
  logic [ADDR_W-1:0] size_m;

  // P-1 for the smallest power of two P >= s
  function automatic logic [ADDR_W-1:0] size_mask(input logic [SW-1:0] s);
    logic [ADDR_W-1:0] m;
    m = '0;
    for (int i = 0; i < ADDR_W; i++)
      if (({2'b00, m} + SIZE_ONE) < s) m = (m << 1) | A_ONE;
    return m;
  endfunction

  assign rise      = bus.ioctl_download & ~dl_prev;
  assign fall      = ~bus.ioctl_download & dl_prev;
  assign in_rom    = (bus.ioctl_addr[24:ADDR_W] == '0);
  assign wr_ok     = (state == LOAD) && bus.ioctl_wr && !end_pend;
  // A write coinciding with the falling edge keeps LOAD one more cycle so it lands first
  assign load_done = (fall && !bus.ioctl_wr) || end_pend;
  assign no_mirror = (rom_size == '0) || (rom_size == ROM_BYTES);
  assign addr_p1   = {2'b00, bus.ioctl_addr[ADDR_W-1:0]} + SIZE_ONE;
  assign size_m    = size_mask(rom_size);
  assign a_lt_p    = ((a & ~p_mask) == '0);

  always_comb begin
    bs_code = 4'd0;
    case (bus.file_ext)
      ".F8":   bs_code = 4'd1;
      ".F6":   bs_code = 4'd2;
      ".FE":   bs_code = 4'd3;
      ".E0":   bs_code = 4'd4;
      ".3F":   bs_code = 4'd5;
      ".F4":   bs_code = 4'd6;
      ".P2":   bs_code = 4'd7;
      ".FA":   bs_code = 4'd8;
      ".CV":   bs_code = 4'd9;
      default: bs_code = 4'd0;
    endcase
  end

  always_comb begin
    sc_code = 1'b0;
    case (bus.sc_mode)
      2'd0:    sc_code = bus.ext_tag_s;
      2'd1:    sc_code = 1'b0;
      default: sc_code = 1'b1;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= HOLD;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (rise) begin
      next_state = LOAD;
    end else begin
      case (state)
        HOLD:     if (hold_cnt <= CNT_ONE) next_state = IDLE;
        IDLE:     next_state = IDLE;
        LOAD:     if (load_done) next_state = no_mirror ? HOLD : MIR_RD;
        MIR_RD:   next_state = MIR_WAIT;
        MIR_WAIT: next_state = MIR_WR;
        MIR_WR:   next_state = (&a) ? HOLD : MIR_RD;
        default:  next_state = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_prev  <= 1'b0;
      end_pend <= 1'b0;
      hold_cnt <= HOLD_INIT;
      a        <= '0;
      p_mask   <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      rom_size <= '0;
      force_bs <= '0;
      sc       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_prev <= bus.ioctl_download;
      mem_we  <= 1'b0;
      if (next_state == HOLD && state != HOLD) hold_cnt <= HOLD_INIT;
      else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - CNT_ONE;

      if (rise) begin
        end_pend <= 1'b0;
        rom_size <= '0;
        overflow <= 1'b0;
        force_bs <= bs_code;
        sc       <= sc_code;
      end else begin
        case (state)
          LOAD: begin
            if (wr_ok) begin
              if (in_rom) begin
                mem_we   <= 1'b1;
                mem_addr <= bus.ioctl_addr[ADDR_W-1:0];
                mem_din  <= bus.ioctl_dout;
                if (addr_p1 > rom_size) rom_size <= addr_p1;
              end else begin
                overflow <= 1'b1;
                rom_size <= ROM_BYTES;
              end
            end
            if (fall && bus.ioctl_wr) end_pend <= 1'b1;
            if (load_done) begin
              end_pend <= 1'b0;
              a        <= rom_size[ADDR_W-1:0];
              p_mask   <= size_m;
              mem_addr <= rom_size[ADDR_W-1:0] & size_m;
            end
          end
          MIR_WAIT: begin
            mem_addr <= a;
            mem_din  <= a_lt_p ? 8'hFF : bus.mem_q;
            mem_we   <= 1'b1;
          end
          MIR_WR: begin
            a        <= a + A_ONE;
            mem_addr <= (a + A_ONE) & p_mask;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CART_CHECKSUM_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                checksum <= '0;
    else if (rise)            checksum <= '0;
    else if (wr_ok && in_rom) checksum <= checksum + {8'h00, bus.ioctl_dout};
  end
`endif

  assign bus.mem_addr   = mem_addr;
  assign bus.mem_din    = mem_din;
  assign bus.mem_we     = mem_we;
  assign bus.core_reset = (state != IDLE);
  assign bus.busy       = (state == LOAD) || (state == MIR_RD) || (state == MIR_WAIT) || (state == MIR_WR);
  assign bus.rom_size   = rom_size;
  assign bus.force_bs   = force_bs;
  assign bus.sc         = sc;
  assign bus.overflow   = overflow;
endmodule

// File: tb/tb_cart_load_ctrl.sv
// tb/tb_cart_load_ctrl.sv - self-checking bench for cart_load_ctrl with a small ROM space
module tb_cart_load_ctrl;
  localparam int AW  = 10;
  localparam int HC  = 16;
  localparam int ROM = 1 << AW;
  localparam int NV  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cart_load_if #(.ADDR_W(AW)) bus ();
`ifdef CART_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  cart_load_ctrl #(.ADDR_W(AW), .HOLD_CYC(HC)) dut (
    .clk_sys  (clk),
    .reset    (rst),
`ifdef CART_CHECKSUM_EN
    .checksum (checksum),
`endif
    .bus      (bus.slave)
  );

  logic [7:0] ram [ROM];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_q <= ram[bus.mem_addr];
  end

  int we_cnt = 0, we_bad = 0, tail_seen = 0, hold_seen = 0;
  always @(negedge clk) begin
    if (bus.mem_we) begin
      we_cnt++;
      if (!bus.busy) we_bad++;
    end
    if (!bus.ioctl_download && bus.busy) tail_seen++;
    if (bus.core_reset && !bus.busy) hold_seen++;
  end

  int checks = 0, errors = 0;
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] img [2048];
  logic [7:0] exp_mem [ROM];

  task automatic load_image(input int size, input bit end_with_wr);
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < size; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = img[i];
      if (end_with_wr && i == size - 1) bus.ioctl_download = 1'b0;
      tick();
      bus.ioctl_wr = 1'b0;
      if (!(end_with_wr && i == size - 1) && $urandom_range(0, 3) == 0) tick();
    end
    bus.ioctl_download = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (bus.core_reset && n < 20000) begin
      tick();
      n++;
    end
    ok = !bus.core_reset;
  endtask

  typedef struct {
    logic [23:0] ext;
    logic [1:0]  mode;
    logic        tag;
    int          size;
    bit          end_with_wr;
    logic [3:0]  exp_bs;
    logic        exp_sc;
    int          exp_size;
    logic        exp_ovf;
  } vec_t;
  vec_t vecs [NV];

  initial begin
    vec_t v;
    bit ok, mirror;
    int s, p, mism, we0, tail0, hold0, sum;

    vecs[0] = '{".F8", 2'd0, 1'b0, 128,  1'b0, 4'd1, 1'b0, 128,  1'b0};
    vecs[1] = '{".F6", 2'd0, 1'b1, 300,  1'b1, 4'd2, 1'b1, 300,  1'b0};
    vecs[2] = '{".E0", 2'd1, 1'b1, 1024, 1'b0, 4'd4, 1'b0, 1024, 1'b0};
    vecs[3] = '{".FE", 2'd2, 1'b0, 1500, 1'b1, 4'd3, 1'b1, 1024, 1'b1};
    vecs[4] = '{".3F", 2'd3, 1'b0, 1,    1'b0, 4'd5, 1'b1, 1,    1'b0};
    vecs[5] = '{".F4", 2'd0, 1'b0, 700,  1'b1, 4'd6, 1'b0, 700,  1'b0};
    vecs[6] = '{".P2", 2'd1, 1'b0, 2,    1'b0, 4'd7, 1'b0, 2,    1'b0};
    vecs[7] = '{".FA", 2'd0, 1'b1, 3,    1'b1, 4'd8, 1'b1, 3,    1'b0};
    vecs[8] = '{".CV", 2'd2, 1'b1, 512,  1'b0, 4'd9, 1'b1, 512,  1'b0};
    vecs[9] = '{".XX", 2'd0, 1'b0, 600,  1'b0, 4'd0, 1'b0, 600,  1'b0};

    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.file_ext       = '0;
    bus.sc_mode        = '0;
    bus.ext_tag_s      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_core_reset", bus.core_reset, 1);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_din", bus.mem_din, 0);
    check("rst_rom_size", bus.rom_size, 0);
    check("rst_force_bs", bus.force_bs, 0);
    check("rst_sc", bus.sc, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overflow", bus.overflow, 0);
    hold0 = hold_seen;
    rst = 1'b0;
    wait_idle(ok);
    check("rst_idle_reached", ok, 1);
    check("rst_hold_cycles", hold_seen - hold0, HC);

    for (int vi = 0; vi < NV; vi++) begin
      v = vecs[vi];
      for (int k = 0; k < 2048; k++) img[k] = 8'($urandom);
      if (v.size == 3) begin
        img[0] = 8'h01; img[1] = 8'hFF; img[2] = 8'h10;
      end
      bus.file_ext  = v.ext;
      bus.sc_mode   = v.mode;
      bus.ext_tag_s = v.tag;
      we0 = we_cnt; tail0 = tail_seen; hold0 = hold_seen;
      load_image(v.size, v.end_with_wr);
      wait_idle(ok);

      s = (v.size < ROM) ? v.size : ROM;
      mirror = (s != 0) && (s != ROM);
      p = 1;
      while (p < s) p = p * 2;
      sum = 0;
      for (int k = 0; k < ROM; k++) begin
        if (k < s) begin
          exp_mem[k] = img[k];
          sum += img[k];
        end else if (k < p) exp_mem[k] = 8'hFF;
        else exp_mem[k] = exp_mem[k % p];
      end
      mism = 0;
      for (int k = 0; k < ROM; k++) if (ram[k] !== exp_mem[k]) mism++;

      check($sformatf("v%0d_idle_reached", vi), ok, 1);
      check($sformatf("v%0d_force_bs", vi), bus.force_bs, v.exp_bs);
      check($sformatf("v%0d_sc", vi), bus.sc, v.exp_sc);
      check($sformatf("v%0d_rom_size", vi), bus.rom_size, v.exp_size);
      check($sformatf("v%0d_overflow", vi), bus.overflow, v.exp_ovf);
      check($sformatf("v%0d_write_count", vi), we_cnt - we0, s + (mirror ? ROM - s : 0));
      check($sformatf("v%0d_busy_tail_cycles", vi), tail_seen - tail0,
            (v.end_with_wr ? 2 : 1) + (mirror ? 3 * (ROM - s) : 0));
      check($sformatf("v%0d_hold_cycles", vi), hold_seen - hold0, HC);
      check($sformatf("v%0d_mem_mismatches", vi), mism, 0);
      check($sformatf("v%0d_we_outside_busy", vi), we_bad, 0);
`ifdef CART_CHECKSUM_EN
      check($sformatf("v%0d_checksum", vi), checksum, sum & 16'hFFFF);
`endif
    end

    // new download while mirroring
    for (int k = 0; k < 2048; k++) img[k] = 8'($urandom);
    bus.file_ext = ".F8";
    load_image(100, 1'b0);
    repeat (60) tick();
    check("abort_was_mirroring", bus.busy, 1);
    bus.ioctl_download = 1'b1;
    tick();
    @(negedge clk);
    check("abort_busy", bus.busy, 1);
    check("abort_rom_size", bus.rom_size, 0);
    check("abort_core_reset", bus.core_reset, 1);
    check("abort_mem_we", bus.mem_we, 0);
    we0 = we_cnt;
    repeat (8) tick();
    check("abort_no_writes", we_cnt - we0, 0);
    bus.ioctl_download = 1'b0;
    wait_idle(ok);
    check("abort_idle_reached", ok, 1);
    check("abort_final_rom_size", bus.rom_size, 0);

    // asynchronous reset in the middle of a load
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = img[i];
      tick();
    end
    bus.ioctl_addr = 25'd10;
    #2;
    rst = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    #1;
    check("arst_core_reset", bus.core_reset, 1);
    check("arst_mem_we", bus.mem_we, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_rom_size", bus.rom_size, 0);
    we0 = we_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold0 = hold_seen;
    wait_idle(ok);
    check("arst_idle_reached", ok, 1);
    check("arst_hold_cycles", hold_seen - hold0, HC);
    check("arst_no_writes", we_cnt - we0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
